// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM capture block and its consumer.
// The capture block takes the master side: it receives the raw PWM pin and
// drives the measurement results and status flags.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             i_pwm;
  logic [7:0]       o_duty;
  logic [CNT_W-1:0] o_high;
  logic [CNT_W:0]   o_period;
  logic             o_valid;
  logic             o_stuck_hi;
  logic             o_stuck_lo;
  logic             o_overrun;

  modport master (
    input  i_pwm,
    output o_duty, o_high, o_period, o_valid, o_stuck_hi, o_stuck_lo, o_overrun
  );

  modport slave (
    output i_pwm,
    input  o_duty, o_high, o_period, o_valid, o_stuck_hi, o_stuck_lo, o_overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input,
// derives an 8-bit duty value with a serial restoring divider, and flags
// inputs that stay at one level for TIMEOUT ticks.
// The interface instance must be built with the same CNT_W as this module.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pwm_capture_if.master bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  // Counter value on the last tick before a level counts as stuck
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_lc;
  logic             r_stuck_hi;
  logic             r_stuck_lo;
  logic             w_stuck_enter;
  logic             w_start;
  logic [CNT_W:0]   w_period_now;

  logic             r_busy;
  logic [2:0]       r_iter;
  logic [CNT_W+1:0] r_rem;
  logic [CNT_W:0]   r_div;
  logic [7:0]       r_quo;
  logic [CNT_W-1:0] r_h_lat;
  logic [CNT_W+1:0] w_rem_sh;
  logic [CNT_W+1:0] w_rem_nx;
  logic             w_ge;
  logic [7:0]       w_quo_nx;

  logic [7:0]       r_duty;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W:0]   r_period;
  logic             r_valid;

  // Two-flop synchronizer plus one cycle of history for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // Timeout detection; an edge in the same cycle always takes precedence
  always_comb begin
    w_stuck_enter = 1'b0;
    case (r_state)
      IDLE:    w_stuck_enter = ~w_rise & (r_lc == LP_LAST);
      HIGH:    w_stuck_enter = ~w_fall & r_sync2 & (r_hc == LP_LAST);
      LOW:     w_stuck_enter = ~w_rise & (r_lc == LP_LAST);
      default: w_stuck_enter = 1'b0;
    endcase
  end

  // The rise cycle itself belongs to the next period, so hc+lc is the full period
  assign w_period_now = {1'b0, r_hc} + {1'b0, r_lc};
  assign w_start      = (r_state == LOW) & w_rise & ~r_busy;

  // Measurement FSM: level counters and the registered stuck flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_hc       <= '0;
      r_lc       <= '0;
      r_stuck_hi <= 1'b0;
      r_stuck_lo <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_hc    <= CNT_W'(1);
            r_lc    <= '0;
          end else if (w_stuck_enter) begin
            r_state    <= STUCK;
            r_stuck_hi <= r_sync2;
            r_stuck_lo <= ~r_sync2;
          end else begin
            r_lc <= r_lc + CNT_W'(1);
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state <= LOW;
            r_lc    <= CNT_W'(1);
          end else if (w_stuck_enter) begin
            r_state    <= STUCK;
            r_stuck_hi <= r_sync2;
            r_stuck_lo <= ~r_sync2;
          end else begin
            r_hc <= r_hc + CNT_W'(1);
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_hc    <= CNT_W'(1);
            r_lc    <= '0;
          end else if (w_stuck_enter) begin
            r_state    <= STUCK;
            r_stuck_hi <= r_sync2;
            r_stuck_lo <= ~r_sync2;
          end else begin
            r_lc <= r_lc + CNT_W'(1);
          end
        end
        STUCK: begin
          if (w_rise) begin
            r_state    <= HIGH;
            r_hc       <= CNT_W'(1);
            r_lc       <= '0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
          end else if (w_fall) begin
            r_state    <= IDLE;
            r_lc       <= CNT_W'(1);
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One restoring step: H < P, so starting the remainder at H yields floor(H*256/P)
  assign w_rem_sh = r_rem << 1;
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
  assign w_quo_nx = (r_quo << 1) | {7'd0, w_ge};

  // Serial divider and result registers; stuck entry overrides any result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_iter   <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_h_lat  <= '0;
      r_duty   <= '0;
      r_high   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_busy) begin
        r_rem  <= w_rem_nx;
        r_quo  <= w_quo_nx;
        r_iter <= r_iter + 3'd1;
        if (r_iter == 3'd7) begin
          r_busy   <= 1'b0;
          r_duty   <= w_quo_nx;
          r_high   <= r_h_lat;
          r_period <= r_div;
          r_valid  <= 1'b1;
        end
      end else if (w_start) begin
        r_busy  <= 1'b1;
        r_iter  <= '0;
        r_rem   <= {2'b00, r_hc};
        r_div   <= w_period_now;
        r_quo   <= '0;
        r_h_lat <= r_hc;
      end
      if (w_stuck_enter) begin
        r_duty   <= r_sync2 ? 8'hFF : 8'h00;
        r_high   <= '0;
        r_period <= '0;
        r_valid  <= 1'b1;
      end
    end
  end

  assign bus.o_duty     = r_duty;
  assign bus.o_high     = r_high;
  assign bus.o_period   = r_period;
  assign bus.o_valid    = r_valid;
  assign bus.o_stuck_hi = r_stuck_hi;
  assign bus.o_stuck_lo = r_stuck_lo;
  // Dropped-sample strobe appears in the rise cycle itself
  assign bus.o_overrun  = ~i_rst & w_rise & (r_state == LOW) & r_busy;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios with literal expectations plus
// randomized PWM segments, all checked every cycle against a timestamp model.
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: pin delay line, level run length, edge timestamps, pending result
  bit               m_init = 0;
  bit               m_s1, m_s, m_p;
  int               cyc, run, rise_cyc, fall_cyc, pend_at;
  bit               has_rise, fall_seen, stuck, pend;
  logic [7:0]       e_duty, pend_duty;
  logic [CNT_W-1:0] e_high, pend_high;
  logic [CNT_W:0]   e_period, pend_period;
  logic             e_valid, e_shi, e_slo;

  // Observed strobes, used by the directed literal checks
  int               n_valid = 0;
  int               n_ovr   = 0;
  logic [7:0]       last_duty;
  logic [CNT_W-1:0] last_high;
  logic [CNT_W:0]   last_period;

  // Compare DUT to the model mid-cycle, then advance the model by one clock
  always @(negedge i_clk) begin
    bit rise, fall, busy, ovr;
    int h, p;
    rise = m_s & ~m_p;
    fall = ~m_s & m_p;
    busy = pend;
    ovr  = !i_rst && m_init && rise && !stuck && has_rise && fall_seen && busy;
    if (m_init) begin
      chk("duty",     32'(bus.o_duty),     32'(e_duty));
      chk("high",     32'(bus.o_high),     32'(e_high));
      chk("period",   32'(bus.o_period),   32'(e_period));
      chk("valid",    32'(bus.o_valid),    32'(e_valid));
      chk("stuck_hi", 32'(bus.o_stuck_hi), 32'(e_shi));
      chk("stuck_lo", 32'(bus.o_stuck_lo), 32'(e_slo));
      chk("overrun",  32'(bus.o_overrun),  32'(ovr));
    end
    if (bus.o_valid === 1'b1) begin
      n_valid++;
      last_duty   = bus.o_duty;
      last_high   = bus.o_high;
      last_period = bus.o_period;
    end
    if (bus.o_overrun === 1'b1) n_ovr++;

    if (i_rst) begin
      m_init = 1; m_s1 = 0; m_s = 0; m_p = 0;
      cyc = 0; run = 0; has_rise = 0; fall_seen = 0; stuck = 0; pend = 0;
      e_duty = '0; e_high = '0; e_period = '0; e_valid = 0; e_shi = 0; e_slo = 0;
    end else if (m_init) begin
      run = (rise || fall) ? 1 : run + 1;
      e_valid = 0;
      if (pend && pend_at == cyc + 1) begin
        e_duty = pend_duty; e_high = pend_high; e_period = pend_period;
        e_valid = 1; pend = 0;
      end
      if (stuck) begin
        if (rise || fall) begin
          e_shi = 0; e_slo = 0; stuck = 0;
          has_rise = rise; rise_cyc = cyc; fall_seen = 0;
        end
      end else if (rise) begin
        if (has_rise && fall_seen && !busy) begin
          h = fall_cyc - rise_cyc;
          p = cyc - rise_cyc;
          pend = 1; pend_at = cyc + 9;
          pend_high   = CNT_W'(h);
          pend_period = (CNT_W+1)'(p);
          pend_duty   = 8'((h * 256) / p);
        end
        has_rise = 1; rise_cyc = cyc; fall_seen = 0;
      end else if (fall) begin
        if (has_rise) begin
          fall_seen = 1; fall_cyc = cyc;
        end
      end else if (run >= TIMEOUT) begin
        stuck = 1; has_rise = 0; fall_seen = 0;
        e_shi = m_s; e_slo = !m_s;
        e_duty = m_s ? 8'hFF : 8'h00; e_high = '0; e_period = '0; e_valid = 1;
      end
      m_p = m_s; m_s = m_s1; m_s1 = bus.i_pwm; cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic seg(input logic lvl, input int n);
    bus.i_pwm = lvl;
    step(n);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
  endtask

  initial begin
    int v0, o0, hl, ll;
    bus.i_pwm = 1'b0;
    i_rst     = 1'b1;
    step(3);
    chk("reset_duty",  32'(bus.o_duty),   32'd0);
    chk("reset_valid", 32'(bus.o_valid),  32'd0);
    chk("reset_per",   32'(bus.o_period), 32'd0);
    i_rst = 1'b0;

    // 64/192 repeated: first rise is not reported, the next five are
    do_reset(); v0 = n_valid;
    seg(0, 10);
    for (int i = 0; i < 6; i++) begin seg(1, 64); seg(0, 192); end
    chk("t1_nvalid", 32'(n_valid - v0), 32'd5);
    chk("t1_duty",   32'(last_duty),    32'd64);
    chk("t1_high",   32'(last_high),    32'd64);
    chk("t1_period", 32'(last_period),  32'd256);

    // 100/156 then 200/56
    do_reset(); o0 = n_ovr;
    seg(0, 10);
    for (int i = 0; i < 3; i++) begin seg(1, 100); seg(0, 156); end
    seg(1, 20);
    chk("t2_duty100", 32'(last_duty), 32'd100);
    chk("t2_high100", 32'(last_high), 32'd100);
    seg(1, 180); seg(0, 56); seg(1, 200); seg(0, 56); seg(1, 20);
    chk("t2_duty200", 32'(last_duty),   32'd200);
    chk("t2_high200", 32'(last_high),   32'd200);
    chk("t2_period",  32'(last_period), 32'd256);
    chk("t2_novr",    32'(n_ovr - o0),  32'd0);

    // 1/2 pulses: of 19 measurable rises, every third starts a divide
    do_reset(); v0 = n_valid; o0 = n_ovr;
    seg(0, 10);
    for (int i = 0; i < 20; i++) begin seg(1, 1); seg(0, 2); end
    seg(0, 20);
    chk("t3_nvalid", 32'(n_valid - v0), 32'd7);
    chk("t3_novr",   32'(n_ovr - o0),   32'd12);
    chk("t3_duty",   32'(last_duty),    32'd85);
    chk("t3_period", 32'(last_period),  32'd3);

    // Held high past TIMEOUT
    do_reset(); v0 = n_valid;
    seg(0, 10); seg(1, 1100);
    chk("t4_stuck_hi", 32'(bus.o_stuck_hi), 32'd1);
    chk("t4_duty",     32'(bus.o_duty),     32'hFF);
    chk("t4_nvalid",   32'(n_valid - v0),   32'd1);
    seg(0, 20);
    chk("t4_cleared",  32'(bus.o_stuck_hi), 32'd0);

    // Held low from reset
    do_reset(); v0 = n_valid;
    seg(0, 1100);
    chk("t5_stuck_lo", 32'(bus.o_stuck_lo), 32'd1);
    chk("t5_duty",     32'(bus.o_duty),     32'd0);
    chk("t5_nvalid",   32'(n_valid - v0),   32'd1);
    seg(1, 20);
    chk("t5_cleared",  32'(bus.o_stuck_lo), 32'd0);

    // Reset four cycles into a divide
    do_reset();
    seg(0, 10);
    for (int i = 0; i < 3; i++) begin seg(1, 64); seg(0, 192); end
    seg(1, 6);
    i_rst = 1'b1;
    step(1);
    chk("t6_duty0",   32'(bus.o_duty),   32'd0);
    chk("t6_high0",   32'(bus.o_high),   32'd0);
    chk("t6_period0", 32'(bus.o_period), 32'd0);
    i_rst = 1'b0; v0 = n_valid;
    seg(1, 58);
    chk("t6_novalid", 32'(n_valid - v0), 32'd0);
    seg(0, 192);
    for (int i = 0; i < 3; i++) begin seg(1, 64); seg(0, 192); end
    seg(1, 20);
    chk("t6_duty",   32'(last_duty),   32'd64);
    chk("t6_period", 32'(last_period), 32'd256);

    // Random segments with occasional long holds and resets
    do_reset();
    for (int i = 0; i < 120; i++) begin
      hl = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1001, 1200)) : int'($urandom_range(1, 260));
      ll = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1001, 1200)) : int'($urandom_range(1, 260));
      seg(1, hl);
      seg(0, ll);
      if ($urandom_range(0, 39) == 0) begin
        i_rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        i_rst = 1'b0;
      end
    end
    seg(0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
